wb_master_engine: RTL and testbench
===================================

Name: wb_master_engine

Overview:
Single-transfer Wishbone B4 classic bus master. It sits at the initiator end of the Wishbone link and drives the inputs seen by a Wishbone slave (CYC, STB, ADR, DAT, SEL, TGA/TGC/TGD, LOCK, WE). It accepts one command at a time on a valid/ready port and runs exactly one bus cycle per command. It handles ACK/ERR/RTY termination, bounded retry with backoff and a no-response timeout, then returns a status/data response on a valid/ready port.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width; SEL width is DATA_W/8
TAG_W, 16, width of TGA/TGC/TGD
MAX_RETRY, 3, number of re-issues after RTY before giving up (0 = never retry)
RETRY_GAP, 2, idle cycles with CYC low between an RTY and the re-issue (minimum 1)
TIMEOUT_CYC, 256, wait cycles without termination before abort (0 = timeout disabled)

Ports:
clk  in  1  bus clock; every register updates on posedge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine idle and able to accept a command
cmd_we  in  1  1 = write, 0 = read
cmd_lock  in  1  copied to LOCK_O for the whole cycle
cmd_adr  in  ADDR_W  address
cmd_dat  in  DATA_W  write data
cmd_sel  in  DATA_W/8  byte selects
cmd_tga, cmd_tgc, cmd_tgd  in  TAG_W each  address, cycle and data tags
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_status  out  2  0 OK, 1 ERR, 2 RTY_EXHAUSTED, 3 TIMEOUT
rsp_dat  out  DATA_W  read data (0 for writes and non-OK results)
rsp_tgd  out  TAG_W  TGD_I captured with the read data
rsp_retries  out  $clog2(MAX_RETRY+1)  number of re-issues performed
CYC_O, STB_O, WE_O, LOCK_O  out  1  Wishbone master controls
ADR_O  out  ADDR_W;  DAT_O  out  DATA_W;  SEL_O  out  DATA_W/8
TGA_O, TGC_O, TGD_O  out  TAG_W
ACK_I, ERR_I, RTY_I  in  1  slave terminations
DAT_I  in  DATA_W;  TGD_I  in  TAG_W  slave read data and data tag

Behaviour:
- Reset: asynchronous on rst_n low. All outputs are 0 and the FSM is in IDLE. A reset in the middle of a bus cycle drops CYC/STB immediately and discards any pending response.
- All bus outputs are registered. No combinational path exists from the Wishbone inputs to the bus outputs.
- FSM states: IDLE, BUS, GAP, RESP.
- IDLE: cmd_ready=1. On an accepting edge (cmd_valid&&cmd_ready), latch the command and clear the retry and timeout counters. Next state is BUS, and CYC_O/STB_O are 1 from that edge onward (1-cycle issue latency). ADR_O, DAT_O, SEL_O, WE_O, LOCK_O and the tags are stable while CYC_O=1.
- BUS: terminations are sampled on each posedge. Priority when more than one is asserted: ERR > RTY > ACK.
  - ACK: capture DAT_I/TGD_I for reads, set status OK, drop CYC/STB, go to RESP.
  - ERR: status ERR, drop CYC/STB, go to RESP.
  - RTY with retry count < MAX_RETRY: increment the count, drop CYC/STB, go to GAP.
  - RTY with retry count = MAX_RETRY: status RTY_EXHAUSTED, go to RESP.
  - No termination: increment the timeout counter. When TIMEOUT_CYC≠0 and TIMEOUT_CYC edges pass with no termination, set status TIMEOUT, drop CYC/STB, go to RESP.
- GAP: CYC/STB stay low for exactly RETRY_GAP cycles. The engine then re-enters BUS with an identical cycle and clears the timeout counter.
- RESP: rsp_valid=1 and all rsp_* fields are stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE; cmd_ready rises on the next cycle (no same-cycle bypass). Minimum command-to-command spacing: IDLE→BUS→RESP→IDLE, i.e. 3 cycles.
- Terminations arriving outside BUS are ignored.
- Counters saturate and never wrap.

Decomposition:
- Package wb_master_pkg holds: the wb_status_e enum (OK, ERR, RTY_EXHAUSTED, TIMEOUT; 2 bits), the wb_mst_state_e enum, and a cmd struct typedef parameterised through package localparams matching the defaults.
- One sub-module, wb_cycle_timer: a loadable down-counter with terminal-count output, shared by the GAP wait and the timeout (only one runs at a time).

Test Plan:
- Write 0x1122334455667788 to address 0x40, SEL=0xFF; slave ACKs after 2 wait states → CYC high for 3 cycles with WE_O=1; rsp_status=0, rsp_dat=0, rsp_retries=0.
- Read from 0x80; slave returns DAT_I=0xDEADBEEF_CAFEF00D and TGD_I=0x5A5A with ACK on the first edge → rsp_dat and rsp_tgd match; CYC high for exactly 1 cycle.
- RTY twice, then ACK → CYC low for RETRY_GAP=2 cycles between attempts; ADR/DAT identical on each attempt; rsp_status=0, rsp_retries=2.
- RTY on every attempt → 4 bus cycles total; rsp_status=2, rsp_retries=3. Also ERR and ACK asserted together → rsp_status=1.
- Slave never responds → CYC drops after 256 wait edges; rsp_status=3. Hold rsp_ready=0 for 10 cycles → response stable and cmd_ready=0 throughout.
- Assert rst_n low mid-BUS → CYC_O/STB_O low asynchronously, rsp_valid=0; after release, cmd_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types and default widths for the single-transfer Wishbone classic master.
package wb_master_pkg;

  localparam int unsigned WbAddrW = 64;
  localparam int unsigned WbDataW = 64;
  localparam int unsigned WbSelW  = WbDataW / 8;
  localparam int unsigned WbTagW  = 16;

  typedef enum logic [1:0] {
    WbOk           = 2'd0,
    WbErr          = 2'd1,
    WbRtyExhausted = 2'd2,
    WbTimeout      = 2'd3
  } wb_status_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StGap  = 2'd2,
    StResp = 2'd3
  } wb_mst_state_e;

  typedef struct packed {
    logic               we;
    logic               lock;
    logic [WbAddrW-1:0] adr;
    logic [WbDataW-1:0] dat;
    logic [WbSelW-1:0]  sel;
    logic [WbTagW-1:0]  tga;
    logic [WbTagW-1:0]  tgc;
    logic [WbTagW-1:0]  tgd;
  } wb_cmd_t;

endpackage

// File: rtl/wb_cycle_timer.sv
// Loadable saturating down-counter; o_tc is high while the count sits at zero.
module wb_cycle_timer #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/wb_master_engine.sv
// Wishbone B4 classic master: one bus cycle per command, with RTY backoff and a
// no-termination timeout, reporting status/data on a valid/ready response port.
module wb_master_engine
  import wb_master_pkg::*;
#(
  parameter int unsigned ADDR_W      = WbAddrW,
  parameter int unsigned DATA_W      = WbDataW,
  parameter int unsigned TAG_W       = WbTagW,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RETRY_GAP   = 2,
  parameter int unsigned TIMEOUT_CYC = 256,
  localparam int unsigned SEL_W      = DATA_W / 8,
  localparam int unsigned RET_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic              cmd_lock,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [TAG_W-1:0]  cmd_tga,
  input  logic [TAG_W-1:0]  cmd_tgc,
  input  logic [TAG_W-1:0]  cmd_tgd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_dat,
  output logic [TAG_W-1:0]  rsp_tgd,
  output logic [RET_W-1:0]  rsp_retries,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  output logic              LOCK_O,
  output logic [ADDR_W-1:0] ADR_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic [SEL_W-1:0]  SEL_O,
  output logic [TAG_W-1:0]  TGA_O,
  output logic [TAG_W-1:0]  TGC_O,
  output logic [TAG_W-1:0]  TGD_O,
  input  logic              ACK_I,
  input  logic              ERR_I,
  input  logic              RTY_I,
  input  logic [DATA_W-1:0] DAT_I,
  input  logic [TAG_W-1:0]  TGD_I
);

  localparam int unsigned TmrMax = (TIMEOUT_CYC > RETRY_GAP) ? TIMEOUT_CYC : RETRY_GAP;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  // Timer counts down to zero, so a wait of N edges loads N-1.
  localparam logic [TmrW-1:0]  GapLoad   = TmrW'((RETRY_GAP > 0) ? RETRY_GAP - 1 : 0);
  localparam logic [TmrW-1:0]  ToLoad    = TmrW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [RET_W-1:0] MaxRetryV = RET_W'(MAX_RETRY);
  localparam bit               TimeoutEn = (TIMEOUT_CYC != 0);

  wb_mst_state_e     r_state;
  logic              r_cmd_ready;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic              r_lock;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [SEL_W-1:0]  r_sel;
  logic [TAG_W-1:0]  r_tga;
  logic [TAG_W-1:0]  r_tgc;
  logic [TAG_W-1:0]  r_tgd;
  logic              r_rsp_valid;
  wb_status_e        r_status;
  logic [DATA_W-1:0] r_rsp_dat;
  logic [TAG_W-1:0]  r_rsp_tgd;
  logic [RET_W-1:0]  r_retries;

  logic            w_accept;
  logic            w_done;
  logic            w_retry;
  wb_status_e      w_status;
  logic            w_tmr_load;
  logic [TmrW-1:0] w_tmr_val;
  logic            w_tmr_en;
  logic            w_tmr_tc;

  assign w_accept = r_cmd_ready && cmd_valid;

  wb_cycle_timer #(
    .WIDTH(TmrW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_tmr_load),
    .i_load_val(w_tmr_val),
    .i_en      (w_tmr_en),
    .o_tc      (w_tmr_tc)
  );

  // Termination decode (ERR > RTY > ACK) and timer control.
  always_comb begin
    w_done     = 1'b0;
    w_retry    = 1'b0;
    w_status   = WbOk;
    w_tmr_load = 1'b0;
    w_tmr_val  = ToLoad;
    w_tmr_en   = 1'b0;
    unique case (r_state)
      StIdle: w_tmr_load = w_accept;
      StBus: begin
        if (ERR_I) begin
          w_done   = 1'b1;
          w_status = WbErr;
        end else if (RTY_I) begin
          if (r_retries < MaxRetryV) begin
            w_retry    = 1'b1;
            w_tmr_load = 1'b1;
            w_tmr_val  = GapLoad;
          end else begin
            w_done   = 1'b1;
            w_status = WbRtyExhausted;
          end
        end else if (ACK_I) begin
          w_done = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
          if (TimeoutEn && w_tmr_tc) begin
            w_done   = 1'b1;
            w_status = WbTimeout;
          end
        end
      end
      StGap: begin
        if (w_tmr_tc) w_tmr_load = 1'b1;
        else          w_tmr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_lock      <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_tga       <= '0;
      r_tgc       <= '0;
      r_tgd       <= '0;
      r_rsp_valid <= 1'b0;
      r_status    <= WbOk;
      r_rsp_dat   <= '0;
      r_rsp_tgd   <= '0;
      r_retries   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cmd_ready <= ~w_accept;
          if (w_accept) begin
            r_we      <= cmd_we;
            r_lock    <= cmd_lock;
            r_adr     <= cmd_adr;
            r_dat     <= cmd_dat;
            r_sel     <= cmd_sel;
            r_tga     <= cmd_tga;
            r_tgc     <= cmd_tgc;
            r_tgd     <= cmd_tgd;
            r_retries <= '0;
            r_cyc     <= 1'b1;
            r_stb     <= 1'b1;
            r_state   <= StBus;
          end
        end
        StBus: begin
          if (w_retry) begin
            r_retries <= r_retries + RET_W'(1);
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_state   <= StGap;
          end else if (w_done) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_status    <= w_status;
            r_rsp_dat   <= (w_status == WbOk && !r_we) ? DAT_I : '0;
            r_rsp_tgd   <= (w_status == WbOk && !r_we) ? TGD_I : '0;
            r_state     <= StResp;
          end
        end
        StGap: begin
          if (w_tmr_tc) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= StBus;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_status  = r_status;
  assign rsp_dat     = r_rsp_dat;
  assign rsp_tgd     = r_rsp_tgd;
  assign rsp_retries = r_retries;
  assign CYC_O       = r_cyc;
  assign STB_O       = r_stb;
  assign WE_O        = r_we;
  assign LOCK_O      = r_lock;
  assign ADR_O       = r_adr;
  assign DAT_O       = r_dat;
  assign SEL_O       = r_sel;
  assign TGA_O       = r_tga;
  assign TGC_O       = r_tgc;
  assign TGD_O       = r_tgd;

endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine: scripted slave, timeline model of CYC per
// cycle plus expected response, and literal per-test expectations.
module tb_wb_master_engine;
  import wb_master_pkg::*;

  localparam int TimeoutCyc = 256;
  localparam int MaxRetry   = 3;
  localparam int RetryGap   = 2;
  localparam int TermAck    = 0;
  localparam int TermErr    = 1;
  localparam int TermRty    = 2;
  localparam int TermNone   = 3;
  localparam int TermErrAck = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic        cmd_lock = 1'b0;
  logic [63:0] cmd_adr = '0;
  logic [63:0] cmd_dat = '0;
  logic [7:0]  cmd_sel = '0;
  logic [15:0] cmd_tga = '0;
  logic [15:0] cmd_tgc = '0;
  logic [15:0] cmd_tgd = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic [63:0] rsp_dat;
  logic [15:0] rsp_tgd;
  logic [1:0]  rsp_retries;
  logic        CYC_O, STB_O, WE_O, LOCK_O;
  logic [63:0] ADR_O, DAT_O;
  logic [7:0]  SEL_O;
  logic [15:0] TGA_O, TGC_O, TGD_O;
  logic        ACK_I = 1'b0;
  logic        ERR_I = 1'b0;
  logic        RTY_I = 1'b0;
  logic [63:0] DAT_I = '0;
  logic [15:0] TGD_I = '0;

  int checks = 0;
  int failures = 0;

  wb_cmd_t     cur;
  bit          exp_q[$];
  logic [1:0]  exp_st;
  logic [63:0] exp_dat;
  logic [15:0] exp_tgd;
  logic [1:0]  exp_ret;
  bit          mon_on = 1'b0;
  int          ph = 0;
  int          cyc_cnt = 0;

  int          sc_wait[$];
  int          sc_term[$];
  int          sl_wait[$];
  int          sl_term[$];
  int          sl_cnt = 0;
  logic [63:0] sl_dat = '0;
  logic [15:0] sl_tgd = '0;

  always #5 clk = ~clk;

  wb_master_engine u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_lock   (cmd_lock),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .cmd_sel    (cmd_sel),
    .cmd_tga    (cmd_tga),
    .cmd_tgc    (cmd_tgc),
    .cmd_tgd    (cmd_tgd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_status (rsp_status),
    .rsp_dat    (rsp_dat),
    .rsp_tgd    (rsp_tgd),
    .rsp_retries(rsp_retries),
    .CYC_O      (CYC_O),
    .STB_O      (STB_O),
    .WE_O       (WE_O),
    .LOCK_O     (LOCK_O),
    .ADR_O      (ADR_O),
    .DAT_O      (DAT_O),
    .SEL_O      (SEL_O),
    .TGA_O      (TGA_O),
    .TGC_O      (TGC_O),
    .TGD_O      (TGD_O),
    .ACK_I      (ACK_I),
    .ERR_I      (ERR_I),
    .RTY_I      (RTY_I),
    .DAT_I      (DAT_I),
    .TGD_I      (TGD_I)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scripted slave: per attempt, wait N cycles then terminate as scripted.
  always @(negedge clk) begin
    ACK_I = 1'b0;
    ERR_I = 1'b0;
    RTY_I = 1'b0;
    DAT_I = 64'h0BAD_0BAD_0BAD_0BAD;
    TGD_I = 16'hB0B0;
    if (CYC_O && STB_O && sl_wait.size() > 0) begin
      if (sl_cnt >= sl_wait[0] && sl_term[0] != TermNone) begin
        ACK_I = (sl_term[0] == TermAck) || (sl_term[0] == TermErrAck);
        ERR_I = (sl_term[0] == TermErr) || (sl_term[0] == TermErrAck);
        RTY_I = (sl_term[0] == TermRty);
        DAT_I = sl_dat;
        TGD_I = sl_tgd;
        void'(sl_wait.pop_front());
        void'(sl_term.pop_front());
        sl_cnt = 0;
      end else begin
        sl_cnt++;
      end
    end else begin
      sl_cnt = 0;
    end
  end

  // Compare process: bus timeline, then held response, then return to idle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (ph == 1 && exp_q.size() == 0) ph = 2;
      if (ph == 1) begin
        bit e;
        e = exp_q.pop_front();
        chk("cyc", 64'(CYC_O), 64'(e));
        chk("stb", 64'(STB_O), 64'(e));
        chk("rsp_valid_busy", 64'(rsp_valid), 64'd0);
        chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        if (e) begin
          chk("adr", ADR_O, cur.adr);
          chk("dat_o", DAT_O, cur.dat);
          chk("sel", 64'(SEL_O), 64'(cur.sel));
          chk("we", 64'(WE_O), 64'(cur.we));
          chk("lock", 64'(LOCK_O), 64'(cur.lock));
          chk("tga", 64'(TGA_O), 64'(cur.tga));
          chk("tgc", 64'(TGC_O), 64'(cur.tgc));
          chk("tgd_o", 64'(TGD_O), 64'(cur.tgd));
        end
        if (CYC_O) cyc_cnt++;
      end else if (ph == 2) begin
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("cyc_resp", 64'(CYC_O), 64'd0);
        chk("stb_resp", 64'(STB_O), 64'd0);
        chk("cmd_ready_resp", 64'(cmd_ready), 64'd0);
        chk("rsp_status", 64'(rsp_status), 64'(exp_st));
        chk("rsp_dat", rsp_dat, exp_dat);
        chk("rsp_tgd", 64'(rsp_tgd), 64'(exp_tgd));
        chk("rsp_retries", 64'(rsp_retries), 64'(exp_ret));
        if (rsp_ready) ph = 3;
      end else if (ph == 3) begin
        chk("rsp_valid_done", 64'(rsp_valid), 64'd0);
        chk("cmd_ready_done", 64'(cmd_ready), 64'd1);
        ph = 0;
        mon_on = 1'b0;
      end
    end
  end

  task automatic run(input wb_cmd_t c, input int hold, input logic [1:0] l_st,
                     input logic [63:0] l_dat, input logic [15:0] l_tgd,
                     input logic [1:0] l_ret, input int l_cyc);
    int          ret;
    bit          done;
    int          n;
    logic [1:0]  g_st;
    logic [63:0] g_dat;
    logic [15:0] g_tgd;
    logic [1:0]  g_ret;
    ret = 0;
    done = 1'b0;
    exp_q.delete();
    exp_st = 2'd0;
    exp_dat = '0;
    exp_tgd = '0;
    for (int a = 0; a < sc_wait.size() && !done; a++) begin
      if (sc_term[a] == TermNone) begin
        repeat (TimeoutCyc) exp_q.push_back(1'b1);
        exp_st = 2'd3;
        done = 1'b1;
      end else begin
        repeat (sc_wait[a] + 1) exp_q.push_back(1'b1);
        if (sc_term[a] == TermErr || sc_term[a] == TermErrAck) begin
          exp_st = 2'd1;
          done = 1'b1;
        end else if (sc_term[a] == TermRty) begin
          if (ret < MaxRetry) begin
            ret++;
            repeat (RetryGap) exp_q.push_back(1'b0);
          end else begin
            exp_st = 2'd2;
            done = 1'b1;
          end
        end else begin
          if (!c.we) begin
            exp_dat = sl_dat;
            exp_tgd = sl_tgd;
          end
          done = 1'b1;
        end
      end
    end
    exp_ret = 2'(ret);
    cur = c;
    cmd_we = c.we;
    cmd_lock = c.lock;
    cmd_adr = c.adr;
    cmd_dat = c.dat;
    cmd_sel = c.sel;
    cmd_tga = c.tga;
    cmd_tgc = c.tgc;
    cmd_tgd = c.tgd;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("accept_wait", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    sl_wait = sc_wait;
    sl_term = sc_term;
    sl_cnt = 0;
    cyc_cnt = 0;
    ph = 1;
    mon_on = 1'b1;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (rsp_valid !== 1'b1) begin
      chk("rsp_wait", 64'(rsp_valid), 64'd1);
      mon_on = 1'b0;
      ph = 0;
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    g_st = rsp_status;
    g_dat = rsp_dat;
    g_tgd = rsp_tgd;
    g_ret = rsp_retries;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk); #1;
    chk("lit_status", 64'(g_st), 64'(l_st));
    chk("lit_dat", g_dat, l_dat);
    chk("lit_tgd", 64'(g_tgd), 64'(l_tgd));
    chk("lit_retries", 64'(g_ret), 64'(l_ret));
    chk("lit_cyc_cycles", 64'(cyc_cnt), 64'(l_cyc));
    mon_on = 1'b0;
    ph = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wb_cmd_t c;
    int n;
    #12;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("reset_cyc", 64'(CYC_O), 64'd0);
    chk("reset_stb", 64'(STB_O), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_adr", ADR_O, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write with two wait states.
    c = '{we: 1'b1, lock: 1'b0, adr: 64'h40, dat: 64'h1122334455667788, sel: 8'hFF,
          tga: 16'h0011, tgc: 16'h0022, tgd: 16'h0033};
    sc_wait = '{2};
    sc_term = '{TermAck};
    sl_dat = 64'h0123_4567_89AB_CDEF;
    sl_tgd = 16'h7777;
    run(c, 0, 2'd0, 64'd0, 16'd0, 2'd0, 3);

    // Zero-wait read.
    c = '{we: 1'b0, lock: 1'b0, adr: 64'h80, dat: 64'h0, sel: 8'hFF,
          tga: 16'h1000, tgc: 16'h2000, tgd: 16'h3000};
    sc_wait = '{0};
    sc_term = '{TermAck};
    sl_dat = 64'hDEADBEEF_CAFEF00D;
    sl_tgd = 16'h5A5A;
    run(c, 0, 2'd0, 64'hDEADBEEF_CAFEF00D, 16'h5A5A, 2'd0, 1);

    // Two retries then ACK, locked write.
    c = '{we: 1'b1, lock: 1'b1, adr: 64'h100, dat: 64'hA5A5_5A5A_0F0F_F0F0, sel: 8'h3C,
          tga: 16'hAAAA, tgc: 16'hBBBB, tgd: 16'hCCCC};
    sc_wait = '{1, 0, 0};
    sc_term = '{TermRty, TermRty, TermAck};
    run(c, 0, 2'd0, 64'd0, 16'd0, 2'd2, 4);

    // Retry exhaustion.
    c = '{we: 1'b0, lock: 1'b0, adr: 64'h200, dat: 64'h0, sel: 8'h0F,
          tga: 16'h0001, tgc: 16'h0002, tgd: 16'h0003};
    sc_wait = '{0, 0, 0, 0};
    sc_term = '{TermRty, TermRty, TermRty, TermRty};
    run(c, 0, 2'd2, 64'd0, 16'd0, 2'd3, 4);

    // ERR and ACK together: ERR wins.
    c = '{we: 1'b0, lock: 1'b0, adr: 64'h300, dat: 64'h0, sel: 8'hF0,
          tga: 16'h0004, tgc: 16'h0005, tgd: 16'h0006};
    sc_wait = '{1};
    sc_term = '{TermErrAck};
    run(c, 0, 2'd1, 64'd0, 16'd0, 2'd0, 2);

    // Silent slave, response held for 10 cycles.
    c = '{we: 1'b0, lock: 1'b1, adr: 64'h400, dat: 64'h0, sel: 8'hFF,
          tga: 16'h0007, tgc: 16'h0008, tgd: 16'h0009};
    sc_wait = '{0};
    sc_term = '{TermNone};
    run(c, 10, 2'd3, 64'd0, 16'd0, 2'd0, TimeoutCyc);

    // Reset in the middle of a bus cycle.
    @(posedge clk); #1;
    cmd_we = 1'b0;
    cmd_adr = 64'h500;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    sl_wait = '{0};
    sl_term = '{TermNone};
    repeat (3) @(posedge clk);
    #4;
    chk("mid_bus_cyc", 64'(CYC_O), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", 64'(CYC_O), 64'd0);
    chk("async_rst_stb", 64'(STB_O), 64'd0);
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    sl_wait.delete();
    sl_term.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // Normal read after reset.
    c = '{we: 1'b0, lock: 1'b0, adr: 64'h600, dat: 64'h0, sel: 8'h81,
          tga: 16'h0A0A, tgc: 16'h0B0B, tgd: 16'h0C0C};
    sc_wait = '{1};
    sc_term = '{TermAck};
    sl_dat = 64'h0000_1111_2222_3333;
    sl_tgd = 16'h4444;
    run(c, 0, 2'd0, 64'h0000_1111_2222_3333, 16'h4444, 2'd0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
